// File: rtl/audio_pkg.sv
// Shared audio-path types and constants.
// Covers the codec capture path: sample type, receiver FSM states and I2S framing.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        StWaitFrame,
        StSkip,
        StShift,
        StHold
    } adc_rx_state_t;

    typedef enum logic {
        ChanL = 1'b0,
        ChanR = 1'b1
    } adc_chan_t;

    // I2S places the MSB one bit clock after the word-clock edge.
    localparam int unsigned I2S_DELAY_BITS = 1;

endpackage

// File: rtl/adc_receiver_if.sv
// Stereo sample handshake between the ADC receiver (master) and its consumer (slave).
interface adc_receiver_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] LDATA_IN;
    logic [DATA_WIDTH-1:0] RDATA_IN;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  overrun;
    logic                  clr_overrun;

    modport master (
        output LDATA_IN,
        output RDATA_IN,
        output sample_valid,
        output overrun,
        input  sample_ready,
        input  clr_overrun
    );

    modport slave (
        input  LDATA_IN,
        input  RDATA_IN,
        input  sample_valid,
        input  overrun,
        output sample_ready,
        output clr_overrun
    );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input plus one-cycle rise/fall pulses.
// The level output is delayed to line up with the pulses so sampled data keeps its skew.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Bits [SYNC_STAGES-1:0] synchronise; the next flop feeds the edge detectors.
    logic [SYNC_STAGES+1:0] chain_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES:0], din_i};
        end
    end

    assign level_o = chain_q[SYNC_STAGES];
    assign rise_o  = chain_q[SYNC_STAGES] & ~chain_q[SYNC_STAGES+1];
    assign fall_o  = ~chain_q[SYNC_STAGES] & chain_q[SYNC_STAGES+1];

endmodule

// File: rtl/adc_receiver.sv
// WM8731 ADC capture: oversamples the I2S link in the system clock domain and
// presents completed left/right pairs through a valid/ready handshake.
module adc_receiver
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               AUD_BCLK,
    input  logic               AUD_ADCLRCK,
    input  logic               AUD_ADCDAT,
    adc_receiver_if.master     rx
);

    localparam int unsigned       CntW    = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0]   CntFull = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0]   CntSkip = CntW'(I2S_DELAY_BITS);

    logic bclk_rise, lrck_rise, lrck_fall, adc_dat;
    logic bclk_level_unused, bclk_fall_unused, lrck_level_unused;
    logic dat_rise_unused, dat_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .Clk     (Clk),
        .Reset   (Reset),
        .din_i   (AUD_BCLK),
        .level_o (bclk_level_unused),
        .rise_o  (bclk_rise),
        .fall_o  (bclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .Clk     (Clk),
        .Reset   (Reset),
        .din_i   (AUD_ADCLRCK),
        .level_o (lrck_level_unused),
        .rise_o  (lrck_rise),
        .fall_o  (lrck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .Clk     (Clk),
        .Reset   (Reset),
        .din_i   (AUD_ADCDAT),
        .level_o (adc_dat),
        .rise_o  (dat_rise_unused),
        .fall_o  (dat_fall_unused)
    );

    adc_rx_state_t         state_q, state_d;
    adc_chan_t             chan_q, chan_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shifted, word;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] l_stage_q, l_stage_d;
    logic [DATA_WIDTH-1:0] ldata_q, ldata_d, rdata_q, rdata_d;
    logic                  valid_q, valid_d, overrun_q, overrun_d;
    logic                  word_done, lrck_edge, overrun_set;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StWaitFrame;
            chan_q    <= ChanL;
            shreg_q   <= '0;
            cnt_q     <= '0;
            l_stage_q <= '0;
            ldata_q   <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            l_stage_q <= l_stage_d;
            ldata_q   <= ldata_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        word      = shreg_q;
        shifted   = {shreg_q[DATA_WIDTH-2:0], adc_dat};
        lrck_edge = lrck_rise | lrck_fall;

        // Any word-clock edge once framed restarts capture on the new channel.
        if (state_q != StWaitFrame && lrck_edge) begin
            state_d = StSkip;
            chan_d  = lrck_rise ? ChanR : ChanL;
            cnt_d   = '0;
            shreg_d = '0;
        end

        case (state_q)
            StWaitFrame: begin
                if (lrck_fall) begin
                    state_d = StSkip;
                    chan_d  = ChanL;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            StSkip: begin
                if (!lrck_edge && bclk_rise) begin
                    if (cnt_q + CntW'(1) == CntSkip) begin
                        state_d = StShift;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StShift: begin
                if (lrck_edge) begin
                    // Short word: left-align, missing LSBs read as zero.
                    word_done = 1'b1;
                    word      = shreg_q << (CntFull - cnt_q);
                end else if (bclk_rise) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q + CntW'(1) == CntFull) begin
                        word_done = 1'b1;
                        word      = shifted;
                        state_d   = StHold;
                    end
                end
            end
            StHold: ;
            default: state_d = StWaitFrame;
        endcase
    end

    always_comb begin
        l_stage_d   = l_stage_q;
        ldata_d     = ldata_q;
        rdata_d     = rdata_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;

        if (valid_q && rx.sample_ready) begin
            valid_d = 1'b0;
        end

        if (word_done && chan_q == ChanL) begin
            l_stage_d = word;
        end

        if (word_done && chan_q == ChanR) begin
            if (!valid_q || rx.sample_ready) begin
                ldata_d = l_stage_q;
                rdata_d = word;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (rx.clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign rx.LDATA_IN     = ldata_q;
    assign rx.RDATA_IN     = rdata_q;
    assign rx.sample_valid = valid_q;
    assign rx.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_receiver.sv
// Bench for adc_receiver: drives an I2S stream at 8 Clk per BCLK and checks the
// published pairs against a frame-level model of what each channel slot should yield.
module tb_adc_receiver;
    import audio_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    logic bclk  = 1'b0;
    logic lrck  = 1'b0;
    logic dat   = 1'b0;

    adc_receiver_if #(.DATA_WIDTH(16)) rx ();

    adc_receiver #(
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .rx          (rx)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    sample_t obs_l[$], obs_r[$], exp_l[$], exp_r[$];
    int      valid_cycles = 0;
    int      stab_err     = 0;
    logic    prev_hold    = 1'b0;
    sample_t prev_l, prev_r;

    // Transfer monitor, sampled mid-cycle after the bench has driven its inputs.
    always @(negedge Clk) begin
        #1;
        if (!Reset) begin
            if (rx.sample_valid) valid_cycles++;
            if (rx.sample_valid && rx.sample_ready) begin
                obs_l.push_back(rx.LDATA_IN);
                obs_r.push_back(rx.RDATA_IN);
            end
            if (prev_hold && (rx.LDATA_IN !== prev_l || rx.RDATA_IN !== prev_r)) stab_err++;
            prev_hold = rx.sample_valid && !rx.sample_ready;
            prev_l    = rx.LDATA_IN;
            prev_r    = rx.RDATA_IN;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Word a channel slot of nbclk bit clocks should yield: first data bits, left-aligned.
    function automatic sample_t exp_word(input logic [31:0] bits, input int nbclk);
        int      n;
        sample_t w;
        n = (nbclk - 1 < 16) ? nbclk - 1 : 16;
        w = bits[31:16];
        for (int b = 0; b < 16 - n; b++) w[b] = 1'b0;
        return w;
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One channel slot; bits[31] is the first data bit after the delay slot.
    task automatic send_seg(input logic lr, input logic [31:0] bits, input int nbclk);
        for (int i = 0; i < nbclk; i++) begin
            @(negedge Clk);
            bclk = 1'b0;
            lrck = lr;
            dat  = (i == 0) ? 1'b0 : bits[32-i];
            clk_wait(3);
            @(negedge Clk);
            bclk = 1'b1;
            clk_wait(3);
        end
    endtask

    task automatic send_frame(input logic [31:0] lb, input int lc, input logic [31:0] rb,
                              input int rc, input bit track);
        send_seg(1'b0, lb, lc);
        send_seg(1'b1, rb, rc);
        if (track) begin
            exp_l.push_back(exp_word(lb, lc));
            exp_r.push_back(exp_word(rb, rc));
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        bclk  = 1'b0;
        lrck  = 1'b0;
        dat   = 1'b0;
        clk_wait(4);
        Reset = 1'b0;
        obs_l.delete(); obs_r.delete(); exp_l.delete(); exp_r.delete();
        valid_cycles = 0;
        stab_err     = 0;
    endtask

    task automatic start_stream();
        do_reset();
        send_seg(1'b1, $urandom, 6);
    endtask

    task automatic end_stream();
        send_seg(1'b0, 32'h0, 4);
        clk_wait(10);
    endtask

    task automatic test_reset();
        rx.sample_ready = 1'b0;
        rx.clr_overrun  = 1'b0;
        clk_wait(4);
        total++; if (rx.sample_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid: got %b want 0", rx.sample_valid); end
        total++; if (rx.overrun !== 1'b0) begin bad++;
            $display("FAIL reset_overrun: got %b want 0", rx.overrun); end
        total++; if (rx.LDATA_IN !== 16'h0) begin bad++;
            $display("FAIL reset_ldata: got %h want 0000", rx.LDATA_IN); end
        total++; if (rx.RDATA_IN !== 16'h0) begin bad++;
            $display("FAIL reset_rdata: got %h want 0000", rx.RDATA_IN); end
    endtask

    task automatic test_basic();
        rx.sample_ready = 1'b1;
        start_stream();
        for (int f = 0; f < 3; f++)
            send_frame({16'h8001, 16'($urandom)}, 32, {16'h7FFE, 16'($urandom)}, 32, 1'b1);
        end_stream();
        total++; if (obs_l.size() !== 3) begin bad++;
            $display("FAIL basic_count: got %0d want 3", obs_l.size()); end
        for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
            total++; if ({obs_l[i], obs_r[i]} !== {exp_l[i], exp_r[i]}) begin bad++;
                $display("FAIL basic_pair%0d: got %h/%h want %h/%h", i, obs_l[i], obs_r[i],
                         exp_l[i], exp_r[i]); end
        end
        total++; if (valid_cycles !== 3) begin bad++;
            $display("FAIL basic_valid_pulses: got %0d want 3", valid_cycles); end
        total++; if (rx.overrun !== 1'b0) begin bad++;
            $display("FAIL basic_overrun: got %b want 0", rx.overrun); end
    endtask

    task automatic test_overrun();
        rx.sample_ready = 1'b0;
        start_stream();
        send_frame({16'h1111, 16'($urandom)}, 32, {16'h2222, 16'($urandom)}, 32, 1'b0);
        total++; if ({rx.sample_valid, rx.LDATA_IN, rx.RDATA_IN} !== {1'b1, 32'h1111_2222})
            begin bad++;
            $display("FAIL ovr_first_hold: got v=%b %h/%h want v=1 1111/2222",
                     rx.sample_valid, rx.LDATA_IN, rx.RDATA_IN); end
        total++; if (rx.overrun !== 1'b0) begin bad++;
            $display("FAIL ovr_early: got %b want 0", rx.overrun); end
        send_frame($urandom, 32, $urandom, 32, 1'b0);
        total++; if (rx.overrun !== 1'b1) begin bad++;
            $display("FAIL ovr_set: got %b want 1", rx.overrun); end
        total++; if ({rx.LDATA_IN, rx.RDATA_IN} !== 32'h1111_2222) begin bad++;
            $display("FAIL ovr_second_hold: got %h/%h want 1111/2222",
                     rx.LDATA_IN, rx.RDATA_IN); end
        total++; if (stab_err !== 0) begin bad++;
            $display("FAIL ovr_stable: got %0d changes want 0", stab_err); end
        @(negedge Clk); rx.clr_overrun = 1'b1;
        @(negedge Clk); rx.clr_overrun = 1'b0;
        clk_wait(1);
        total++; if (rx.overrun !== 1'b0) begin bad++;
            $display("FAIL ovr_clear: got %b want 0", rx.overrun); end
        rx.sample_ready = 1'b1;
        clk_wait(3);
        total++; if (obs_l.size() !== 1) begin bad++;
            $display("FAIL ovr_count: got %0d want 1", obs_l.size()); end
        else begin
            total++; if ({obs_l[0], obs_r[0]} !== 32'h1111_2222) begin bad++;
                $display("FAIL ovr_pair: got %h/%h want 1111/2222", obs_l[0], obs_r[0]); end
        end
        total++; if (rx.sample_valid !== 1'b0) begin bad++;
            $display("FAIL ovr_valid_drop: got %b want 0", rx.sample_valid); end
        end_stream();
    endtask

    task automatic test_short();
        rx.sample_ready = 1'b1;
        start_stream();
        // Delay slot plus 12 data bits per channel.
        send_frame({12'hABC, 20'($urandom)}, 13, $urandom, 13, 1'b1);
        end_stream();
        total++; if (obs_l.size() !== 1) begin bad++;
            $display("FAIL short_count: got %0d want 1", obs_l.size()); end
        else begin
            total++; if (obs_l[0] !== 16'hABC0) begin bad++;
                $display("FAIL short_left: got %h want abc0", obs_l[0]); end
            total++; if (obs_r[0] !== exp_r[0]) begin bad++;
                $display("FAIL short_right: got %h want %h", obs_r[0], exp_r[0]); end
        end
    endtask

    task automatic test_reset_mid_word();
        rx.sample_ready = 1'b1;
        start_stream();
        send_seg(1'b0, {16'hAAAA, 16'h0}, 32);
        send_seg(1'b1, {16'hBBBB, 16'h0}, 9);
        @(negedge Clk); Reset = 1'b1;
        clk_wait(3);
        Reset = 1'b0;
        clk_wait(2);
        total++; if (obs_l.size() !== 0 || rx.sample_valid !== 1'b0) begin bad++;
            $display("FAIL rstmid_nopub: got %0d pairs v=%b want 0 v=0",
                     obs_l.size(), rx.sample_valid); end
        send_frame({16'h0001, 16'($urandom)}, 32, {16'h0002, 16'($urandom)}, 32, 1'b0);
        end_stream();
        total++; if (obs_l.size() !== 1) begin bad++;
            $display("FAIL rstmid_count: got %0d want 1", obs_l.size()); end
        else begin
            total++; if ({obs_l[0], obs_r[0]} !== 32'h0001_0002) begin bad++;
                $display("FAIL rstmid_pair: got %h/%h want 0001/0002", obs_l[0], obs_r[0]); end
        end
    endtask

    task automatic test_mid_start();
        rx.sample_ready = 1'b1;
        do_reset();
        send_seg(1'b1, $urandom, 20);
        for (int f = 0; f < 2; f++) send_frame($urandom, 32, $urandom, 32, 1'b1);
        end_stream();
        total++; if (obs_l.size() !== 2) begin bad++;
            $display("FAIL midstart_count: got %0d want 2", obs_l.size()); end
        for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
            total++; if ({obs_l[i], obs_r[i]} !== {exp_l[i], exp_r[i]}) begin bad++;
                $display("FAIL midstart_pair%0d: got %h/%h want %h/%h", i, obs_l[i],
                         obs_r[i], exp_l[i], exp_r[i]); end
        end
    endtask

    task automatic test_random_frames();
        rx.sample_ready = 1'b1;
        start_stream();
        for (int f = 0; f < 6; f++)
            send_frame($urandom, int'($urandom_range(10, 32)), $urandom,
                       int'($urandom_range(10, 32)), 1'b1);
        end_stream();
        total++; if (obs_l.size() !== 6) begin bad++;
            $display("FAIL rand_count: got %0d want 6", obs_l.size()); end
        for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
            total++; if ({obs_l[i], obs_r[i]} !== {exp_l[i], exp_r[i]}) begin bad++;
                $display("FAIL rand_pair%0d: got %h/%h want %h/%h", i, obs_l[i], obs_r[i],
                         exp_l[i], exp_r[i]); end
        end
        total++; if (rx.overrun !== 1'b0) begin bad++;
            $display("FAIL rand_overrun: got %b want 0", rx.overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_short();
        test_reset_mid_word();
        test_mid_start();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
